// File: rtl/map_rotator_pkg.sv
// map_rotator_pkg: shared definitions for the display-map rotator.
//   ST_SHOW / ST_BLANK : FSM state encodings (ST_BLANK used only with MAP_ROT_BLANK_EN)
//   idx_width()        : index/counter width helper, max(1, clog2(n))
package map_rotator_pkg;

   localparam logic [0:0] ST_SHOW  = 1'b0;
   localparam logic [0:0] ST_BLANK = 1'b1;

   // Width able to hold 0..n-1, never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      int unsigned w;
      w = 1;
      if (n > 2) begin
         w = $clog2(n);
      end
      return w;
   endfunction

endpackage

// File: rtl/map_rotator_mux_nx1.sv
// map_rotator_mux_nx1: combinational NUM_MAPS:1 selector of WIDTH-bit maps.
// Ports:
//   maps_i : flattened input maps, map k at [k*WIDTH +: WIDTH]
//   sel_i  : select index; out-of-range selects give all zeros
//   map_o  : selected map
module map_rotator_mux_nx1 #(
   parameter int unsigned NUM_MAPS = 4,
   parameter int unsigned WIDTH    = 7,
   parameter int unsigned SEL_W    = 2
) (
   input  logic [NUM_MAPS*WIDTH-1:0] maps_i,
   input  logic [SEL_W-1:0]          sel_i,
   output logic [WIDTH-1:0]          map_o
);

   always_comb begin
      map_o = '0;
      for (int k = 0; k < int'(NUM_MAPS); k++) begin
         if (sel_i == SEL_W'(k)) begin
            map_o = maps_i[k*WIDTH +: WIDTH];
         end
      end
   end

endmodule

// File: rtl/map_rotator.sv
// map_rotator: N-way display-map selector with manual and auto-rotate modes.
// Holds a registered index and drives the selected WIDTH-bit map (1-cycle latency).
// Optional build macro: MAP_ROT_BLANK_EN inserts a BLANK_CYCLES blank gap between
// maps on each auto advance.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   maps_in    : NUM_MAPS flattened maps, map k at [k*WIDTH +: WIDTH]
//   auto_en    : 1 = auto-rotate every DWELL_CYCLES clocks, 0 = manual
//   man_sel    : manual index, latched by man_load (ignored if >= NUM_MAPS)
//   man_load   : single-cycle load strobe
//   pause      : freezes auto timers, index and state
//   out_map    : registered selected map (BLANK_VALUE in reset/blank)
//   cur_idx    : registered current index
//   wrap       : one-cycle pulse on auto advance from NUM_MAPS-1 to 0
module map_rotator
   import map_rotator_pkg::*;
#(
   parameter int unsigned      NUM_MAPS     = 4,
   parameter int unsigned      WIDTH        = 7,
   parameter int unsigned      DWELL_CYCLES = 50000000,
   parameter logic [WIDTH-1:0] BLANK_VALUE  = {WIDTH{1'b1}},
   parameter int unsigned      BLANK_CYCLES = 2,
   localparam int unsigned     SEL_W        = idx_width(NUM_MAPS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_MAPS*WIDTH-1:0] maps_in,
   input  logic                      auto_en,
   input  logic [SEL_W-1:0]          man_sel,
   input  logic                      man_load,
   input  logic                      pause,
   output logic [WIDTH-1:0]          out_map,
   output logic [SEL_W-1:0]          cur_idx,
   output logic                      wrap
);

   localparam int unsigned      CNT_W      = idx_width(DWELL_CYCLES);
   localparam logic [SEL_W-1:0] LAST_IDX   = SEL_W'(NUM_MAPS - 1);
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

   if (NUM_MAPS < 2) begin : g_bad_num_maps
      $error("map_rotator: NUM_MAPS must be >= 2");
   end
   if (DWELL_CYCLES < 1) begin : g_bad_dwell
      $error("map_rotator: DWELL_CYCLES must be >= 1");
   end
   if (BLANK_CYCLES < 1) begin : g_bad_blank
      $error("map_rotator: BLANK_CYCLES must be >= 1");
   end

   logic [SEL_W-1:0] idx_q, idx_d, idx_next;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wrap_q, wrap_d;
   logic [WIDTH-1:0] out_q, out_d, mux_map;
   logic             load_ok, dwell_done;

`ifdef MAP_ROT_BLANK_EN
   localparam int unsigned      BLK_W      = idx_width(BLANK_CYCLES);
   localparam logic [BLK_W-1:0] BLANK_LAST = BLK_W'(BLANK_CYCLES - 1);

   logic [0:0]       state_q, state_d;
   logic [BLK_W-1:0] bcnt_q, bcnt_d;
   logic             blank_done;

   assign blank_done = (bcnt_q == BLANK_LAST);
`endif

   // Out-of-range manual indices are dropped, not clamped.
   assign load_ok    = man_load && (32'(man_sel) < NUM_MAPS);
   assign dwell_done = (cnt_q == DWELL_LAST);
   assign idx_next   = (idx_q == LAST_IDX) ? '0 : idx_q + SEL_W'(1);

   map_rotator_mux_nx1 #(
      .NUM_MAPS (NUM_MAPS),
      .WIDTH    (WIDTH),
      .SEL_W    (SEL_W)
   ) u_mux (
      .maps_i (maps_in),
      .sel_i  (idx_q),
      .map_o  (mux_map)
   );

   // Priority: man_load > manual mode > pause > timer expiry.
   always_comb begin
      idx_d  = idx_q;
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      out_d  = mux_map;
`ifdef MAP_ROT_BLANK_EN
      state_d = state_q;
      bcnt_d  = bcnt_q;
      if (state_q == ST_BLANK) begin
         out_d = BLANK_VALUE;
      end
`endif
      if (load_ok) begin
         idx_d = man_sel;
         cnt_d = '0;
`ifdef MAP_ROT_BLANK_EN
         state_d = ST_SHOW;
         bcnt_d  = '0;
`endif
      end else if (!auto_en) begin
         cnt_d = '0;
`ifdef MAP_ROT_BLANK_EN
         state_d = ST_SHOW;
         bcnt_d  = '0;
`endif
      end else if (!pause) begin
`ifdef MAP_ROT_BLANK_EN
         if (state_q == ST_BLANK) begin
            // Index advances (and wrap pulses) at the end of the gap.
            if (blank_done) begin
               idx_d   = idx_next;
               wrap_d  = (idx_q == LAST_IDX);
               state_d = ST_SHOW;
               bcnt_d  = '0;
            end else begin
               bcnt_d = bcnt_q + BLK_W'(1);
            end
         end else if (dwell_done) begin
            cnt_d   = '0;
            state_d = ST_BLANK;
            bcnt_d  = '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
`else
         if (dwell_done) begin
            cnt_d  = '0;
            idx_d  = idx_next;
            wrap_d = (idx_q == LAST_IDX);
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q  <= '0;
         cnt_q  <= '0;
         wrap_q <= 1'b0;
         out_q  <= BLANK_VALUE;
`ifdef MAP_ROT_BLANK_EN
         state_q <= ST_SHOW;
         bcnt_q  <= '0;
`endif
      end else begin
         idx_q  <= idx_d;
         cnt_q  <= cnt_d;
         wrap_q <= wrap_d;
         out_q  <= out_d;
`ifdef MAP_ROT_BLANK_EN
         state_q <= state_d;
         bcnt_q  <= bcnt_d;
`endif
      end
   end

   assign out_map = out_q;
   assign cur_idx = idx_q;
   assign wrap    = wrap_q;

endmodule

// File: tb/tb_map_rotator.sv
// tb_map_rotator: directed self-checking bench for map_rotator.
// Main instance: NUM_MAPS=4, WIDTH=7, DWELL=3. Second instance: NUM_MAPS=3 (range check).
module tb_map_rotator;

   localparam int unsigned NM = 4;
   localparam int unsigned W  = 7;
   localparam int unsigned DW = 3;

   logic           clk      = 1'b0;
   logic           rst_n    = 1'b0;
   logic           auto_en  = 1'b0;
   logic           auto3    = 1'b0;
   logic           man_load = 1'b0;
   logic           pause    = 1'b0;
   logic [1:0]     man_sel  = 2'd0;
   logic [1:0]     man_sel3 = 2'd0;
   logic [W-1:0]   m [NM];
   logic [NM*W-1:0] maps_in;
   logic [W-1:0]   out_map, out_map3;
   logic [1:0]     cur_idx, cur_idx3;
   logic           wrap, wrap3;

   int n_checks = 0;
   int n_fail   = 0;

   assign maps_in = {m[3], m[2], m[1], m[0]};

   always #5 clk = ~clk;

   map_rotator #(
      .NUM_MAPS     (NM),
      .WIDTH        (W),
      .DWELL_CYCLES (DW),
      .BLANK_CYCLES (2)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .maps_in  (maps_in),
      .auto_en  (auto_en),
      .man_sel  (man_sel),
      .man_load (man_load),
      .pause    (pause),
      .out_map  (out_map),
      .cur_idx  (cur_idx),
      .wrap     (wrap)
   );

   map_rotator #(
      .NUM_MAPS     (3),
      .WIDTH        (W),
      .DWELL_CYCLES (DW),
      .BLANK_CYCLES (2)
   ) dut3 (
      .clk      (clk),
      .rst_n    (rst_n),
      .maps_in  (maps_in[3*W-1:0]),
      .auto_en  (auto3),
      .man_sel  (man_sel3),
      .man_load (man_load),
      .pause    (pause),
      .out_map  (out_map3),
      .cur_idx  (cur_idx3),
      .wrap     (wrap3)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      int   exp_idx [8];
`ifdef MAP_ROT_BLANK_EN
      int   b_idx [6];
      logic [W-1:0] b_out [6];
`endif
      exp_idx = '{1, 1, 2, 2, 2, 3, 3, 3};
      m[0] = 7'b1000001;
      m[1] = 7'b1100011;
      m[2] = 7'b0001000;
      m[3] = 7'b0110000;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_out", 32'(out_map), 32'h7f);
      check("rst_idx", 32'(cur_idx), 0);
      check("rst_wrap", 32'(wrap), 0);
      check("rst_out3", 32'(out_map3), 32'h7f);
      rst_n = 1'b1;
      @(negedge clk);
      check("live_m0", 32'(out_map), 32'(m[0]));

      // Manual load idx 2; dut3 gets out-of-range 3 which must be ignored
      man_sel  = 2'd2;
      man_sel3 = 2'd3;
      man_load = 1'b1;
      @(negedge clk);
      man_load = 1'b0;
      check("load_idx_t1", 32'(cur_idx), 2);
      check("load_out_t1", 32'(out_map), 32'(7'b1000001));
      check("oor_idx_t1", 32'(cur_idx3), 0);
      @(negedge clk);
      check("load_out_t2", 32'(out_map), 32'(7'b0001000));
      check("oor_idx_t2", 32'(cur_idx3), 0);
      check("oor_out_t2", 32'(out_map3), 32'(7'b1000001));
      check("man_wrap", 32'(wrap), 0);

      // Back to idx 0 with counter cleared; dut3 takes a valid index 2
      man_sel  = 2'd0;
      man_sel3 = 2'd2;
      man_load = 1'b1;
      @(negedge clk);
      man_load = 1'b0;
      auto_en  = 1'b1;
      check("load3_idx", 32'(cur_idx3), 2);
      check("load0_idx", 32'(cur_idx), 0);

`ifdef MAP_ROT_BLANK_EN
      // Blank gap of two cycles between map 0 and map 1
      b_idx = '{0, 0, 0, 0, 1, 1};
      b_out = '{7'b1000001, 7'b1000001, 7'b1000001, 7'b1111111, 7'b1111111, 7'b1100011};
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("blank_idx", 32'(cur_idx), 32'(b_idx[i]));
         check("blank_out", 32'(out_map), 32'(b_out[i]));
         check("blank_wrap", 32'(wrap), 0);
      end
`else
      // Auto rotation: advance every 3 cycles, wrap on cycle 12
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         check("auto_idx", 32'(cur_idx), 32'((i / 3) % 4));
         check("auto_wrap", 32'(wrap), 32'(i == 12));
         check("auto_out", 32'(out_map), 32'(m[((i - 1) / 3) % 4]));
      end

      // Pause for 5 cycles once the counter reaches 1
      @(negedge clk);
      check("pre_pause_idx", 32'(cur_idx), 0);
      check("wrap_clear", 32'(wrap), 0);
      pause = 1'b1;
      @(negedge clk);
      m[0] = 7'b0101010;
      @(negedge clk);
      check("pause_live_out", 32'(out_map), 32'(7'b0101010));
      check("pause_idx_a", 32'(cur_idx), 0);
      repeat (3) @(negedge clk);
      check("pause_idx_b", 32'(cur_idx), 0);
      pause = 1'b0;
      m[0]  = 7'b1000001;
      @(negedge clk);
      check("post_pause_idx1", 32'(cur_idx), 0);
      @(negedge clk);
      check("post_pause_idx2", 32'(cur_idx), 1);
      check("post_pause_out", 32'(out_map), 32'(7'b1000001));

      // Run up to the cycle where idx 3 would wrap
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("run_idx", 32'(cur_idx), 32'(exp_idx[i]));
      end
      man_sel  = 2'd1;
      man_load = 1'b1;
      @(negedge clk);
      man_load = 1'b0;
      check("ld_vs_wrap_idx", 32'(cur_idx), 1);
      check("ld_vs_wrap_wrap", 32'(wrap), 0);
      repeat (2) @(negedge clk);
      check("ld_dwell_idx_a", 32'(cur_idx), 1);
      @(negedge clk);
      check("ld_dwell_idx_b", 32'(cur_idx), 2);

      // Leave auto mid-dwell: counter must be cleared, index frozen
      @(negedge clk);
      auto_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("manual_idx", 32'(cur_idx), 2);
         check("manual_wrap", 32'(wrap), 0);
      end
      auto_en = 1'b1;
      repeat (2) @(negedge clk);
      check("reauto_idx_a", 32'(cur_idx), 2);
      @(negedge clk);
      check("reauto_idx_b", 32'(cur_idx), 3);
`endif

      // Asynchronous reset between clock edges
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_out", 32'(out_map), 32'h7f);
      check("async_rst_idx", 32'(cur_idx), 0);
      check("async_rst_wrap", 32'(wrap), 0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
